// File: rtl/seq_shift_rotate_pkg.sv
// Shared definitions for the multi-cycle shift/rotate unit: op codes,
// FSM state encoding and default widths.
package seq_shift_rotate_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CW_DEF    = 5;

  // Codes 5..7 are all pass-through; OP_PASS names the first of them.
  typedef enum logic [2:0] {
    OP_SHR  = 3'd0,
    OP_SHRA = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_PASS = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic is_pass(input logic [2:0] op);
    return op >= 3'(OP_PASS);
  endfunction

endpackage

// File: rtl/seq_shift_rotate_shift_step_1.sv
// One-bit shift/rotate step applied to the accumulator each SHIFT cycle.
module shift_step_1
  import seq_shift_rotate_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
    case (op)
      OP_SHR:  acc_o = {1'b0, acc_i[WIDTH-1:1]};
      OP_SHRA: acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
      OP_SHL:  acc_o = {acc_i[WIDTH-2:0], 1'b0};
      OP_ROR:  acc_o = {acc_i[0], acc_i[WIDTH-1:1]};
      OP_ROL:  acc_o = {acc_i[WIDTH-2:0], acc_i[WIDTH-1]};
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/seq_shift_rotate.sv
// Multi-cycle shift/rotate unit: moves the operand one bit per clock and
// publishes the result on R together with a one-cycle done pulse.
module seq_shift_rotate
  import seq_shift_rotate_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: start is taken only in IDLE (otherwise dropped, no queuing);
  // busy is high while shifting; done pulses for one cycle with R already
  // valid, and R then holds until the next operation completes.

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_step_d;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] r_q;
  logic             busy_q;
  logic             done_q;

  // Only the low CW bits of A form the shift count.
  logic unused_a_hi;
  assign unused_a_hi = ^A[WIDTH-1:CW];

  shift_step_1 #(.WIDTH(WIDTH)) u_step (
    .op    (op_q),
    .acc_i (acc_q),
    .acc_o (acc_step_d)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            acc_q <= B;
            cnt_q <= A[CW-1:0];
            op_q  <= op;
            if (A[CW-1:0] == '0 || is_pass(op)) begin
              state_q <= S_DONE;
              r_q     <= B;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          acc_q <= acc_step_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= S_DONE;
            r_q     <= acc_step_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign R         = r_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_shift_rotate.sv
// Directed bench for seq_shift_rotate: vector table plus hand-written
// sequences for ignored starts and mid-operation clear.
module tb_seq_shift_rotate;
  import seq_shift_rotate_pkg::*;

  logic        clock;
  logic        clear;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] R;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  seq_shift_rotate dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .R         (R),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%08h exp=0x%08h", name, act, exp);
    end
  endtask

  // Launch one operation, scramble the inputs afterwards, then follow it to done.
  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r_exp, input int lat);
    int cyc;
    logic [31:0] r_prev;
    logic bad_busy;
    logic bad_hold;
    logic [31:0] e;
    @(negedge clock);
    r_prev = R;
    start = 1'b1; op = o; A = a; B = b;
    exp_q.push_back(r_exp);
    @(negedge clock);
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    A = $urandom;
    B = $urandom;
    cyc = 1; bad_busy = 1'b0; bad_hold = 1'b0;
    while (!done && cyc <= 40) begin
      if (busy !== (cyc < lat)) bad_busy = 1'b1;
      if (R !== r_prev) bad_hold = 1'b1;
      @(negedge clock);
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(lat));
    check({name, "_busy_profile"}, {31'b0, bad_busy}, 32'd0);
    check({name, "_r_hold_in_flight"}, {31'b0, bad_hold}, 32'd0);
    check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    e = exp_q.pop_front();
    check({name, "_result"}, R, e);
    @(negedge clock);
    check({name, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({name, "_back_idle"}, {30'b0, dbg_state}, {30'b0, S_IDLE});
    check({name, "_r_held"}, R, e);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{"ror1",      OP_ROR,  32'd1,  32'h80000001, 32'hC0000000, 2};
    vecs[1]  = '{"rol4",      OP_ROL,  32'd4,  32'h12345678, 32'h23456781, 5};
    vecs[2]  = '{"shra31",    OP_SHRA, 32'd31, 32'h80000000, 32'hFFFFFFFF, 32};
    vecs[3]  = '{"shr31",     OP_SHR,  32'd31, 32'h80000000, 32'h00000001, 32};
    vecs[4]  = '{"shl33",     OP_SHL,  32'd33, 32'h00000001, 32'h00000002, 2};
    vecs[5]  = '{"shr0",      OP_SHR,  32'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1};
    vecs[6]  = '{"rol32",     OP_ROL,  32'd32, 32'hDEADBEEF, 32'hDEADBEEF, 1};
    vecs[7]  = '{"pass5",     3'd5,    32'd7,  32'hDEADBEEF, 32'hDEADBEEF, 1};
    vecs[8]  = '{"pass7",     3'd7,    32'd3,  32'hCAFEF00D, 32'hCAFEF00D, 1};
    vecs[9]  = '{"shra4_pos", OP_SHRA, 32'd4,  32'h7FFFFFF0, 32'h07FFFFFF, 5};
    vecs[10] = '{"shl31",     OP_SHL,  32'd31, 32'h00000003, 32'h80000000, 32};
    vecs[11] = '{"ror4",      OP_ROR,  32'd4,  32'h12345678, 32'h81234567, 5};
    vecs[12] = '{"shra8_neg", OP_SHRA, 32'd8,  32'h80001234, 32'hFF800012, 9};
    vecs[13] = '{"shr1",      OP_SHR,  32'd1,  32'hFFFFFFFF, 32'h7FFFFFFF, 2};

    clear = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (2) @(negedge clock);
    check("reset_r", R, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
    clear = 1'b0;

    for (int i = 0; i < 14; i++)
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat);

    // Start while busy and start during DONE are both dropped.
    @(negedge clock);
    start = 1'b1; op = OP_ROL; A = 32'd10; B = 32'h12345678;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc <= 40) begin
      if (cyc == 3) begin
        start = 1'b1; op = OP_SHL; A = 32'd1; B = 32'hFFFFFFFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    check("ignored_start_latency", 32'(cyc), 32'd11);
    check("ignored_start_result", R, 32'hD159E048);
    start = 1'b1; op = OP_SHL; A = 32'd1; B = 32'h00000005;
    @(negedge clock);
    start = 1'b0;
    check("start_in_done_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
    check("start_in_done_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    check("start_in_done_still_idle", {30'b0, dbg_state}, {30'b0, S_IDLE});
    check("start_in_done_r", R, 32'hD159E048);

    // Clear mid-operation discards the shift in flight.
    start = 1'b1; op = OP_SHL; A = 32'd20; B = 32'h00000001;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("clear_pre_busy", {31'b0, busy}, 32'd1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clear_r", R, 32'd0);
    check("clear_busy", {31'b0, busy}, 32'd0);
    check("clear_done", {31'b0, done}, 32'd0);
    check("clear_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
    do_op("after_clear_ror1", OP_ROR, 32'd1, 32'h80000001, 32'hC0000000, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shift_rotate.md
Name: seq_shift_rotate

Overview:
- Multi-cycle shift/rotate execution unit for the datapath ALU. Handles SHR, SHRA, SHL, ROR and ROL on a 32-bit operand.
- Moves one bit position per clock, so it needs no 32-way mux tree. Complements the single-cycle combinational rotators.
- Driven by the control unit through a start/busy/done handshake. The result goes on the ALU result bus (Z input).

Parameters:
- WIDTH, 32, operand/result width in bits.
- CW, 5, shift-count width; effective count N = A mod 2^CW.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- clear  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- op  input  3  0=SHR, 1=SHRA, 2=SHL, 3=ROR, 4=ROL, 5..7=pass-through.
- A  input  WIDTH  shift amount source; only A[CW-1:0] used (A mod 32).
- B  input  WIDTH  operand to shift/rotate.
- R  output  WIDTH  registered result.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; R valid and stable from this cycle.

Behaviour:
- Reset (clear=1 at rising edge): state=IDLE, R=0, busy=0, done=0, internal accumulator and counter zeroed. clear has priority over all other inputs, including mid-operation; any in-flight operation is discarded.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: busy=0, done=1.
- IDLE with start=1: latch acc=B, cnt=A[CW-1:0], op_r=op.
  - If cnt==0 or op is pass-through, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT: each cycle applies one 1-bit step to acc and decrements cnt. When cnt==1 at the edge, the final step is applied and the state moves to DONE.
- 1-bit steps:
  - SHR: {0, acc[W-1:1]}
  - SHRA: {acc[W-1], acc[W-1:1]}
  - SHL: {acc[W-2:0], 0}
  - ROR: {acc[0], acc[W-1:1]}
  - ROL: {acc[W-2:0], acc[W-1]}
- DONE: R<=acc on entry, so R is updated in the same edge that raises done. Returns to IDLE next cycle unconditionally.
- Latency: done asserts N+1 cycles after the start cycle. N=0 gives done 1 cycle later with R=B.
- Throughput: a new start is accepted no earlier than the cycle after done (i.e. in IDLE).
- start while busy or in DONE: ignored; no queuing.
- R holds its last value between operations and does not track acc during SHIFT.
- Operands A, B and op are sampled only at the accepted start; later changes have no effect.
- A >= 32: only the low 5 bits count (A=33 behaves as N=1; A=32 behaves as N=0).

Decomposition:
- Shared package holds:
  - op codes (OP_SHR..OP_ROL, OP_PASS);
  - state encoding (S_IDLE, S_SHIFT, S_DONE);
  - WIDTH/CW defaults.
- One combinational sub-module, shift_step_1 (inputs op, acc; output next acc), keeps the FSM module free of datapath muxing.

Test Plan:
- ROR, A=1, B=0x80000001 -> busy for 1 cycle, done at start+2, R=0xC0000000.
- ROL, A=4, B=0x12345678 -> done at start+5, R=0x23456781. busy high cycles start+1..start+4.
- SHRA, A=31, B=0x80000000 -> R=0xFFFFFFFF at start+32. SHR with same inputs -> R=0x00000001.
- SHL, A=33, B=0x00000001 -> R=0x00000002 at start+2. A=0, any op, B=0xDEADBEEF -> done at start+1, R=0xDEADBEEF.
- ROL A=10 in flight; second start at start+3 with B=0xFFFFFFFF -> ignored; the first op's result is delivered at start+11.
- SHL A=20 in flight; clear asserted at start+5 -> next cycle R=0, busy=0, done=0, state IDLE. A new start is then accepted normally.
